register_checkpoint_buffer: RTL and testbench
=============================================

// Module: register_checkpoint_buffer
// PURPOSE
//  Multi-entry register-file checkpoint store for speculative branch execution.
//  Hazard control pushes a full architectural register image per predicted branch.
//  Correct predictions retire the oldest checkpoint; a mispredict restores the image
//  of the mispredicted branch and discards it plus all younger checkpoints.
//  Sits between hazard control and reg file; replaces the single-image snapshot.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  NUM_REGS    32  registers per checkpoint image
//  DEPTH       4   max in-flight checkpoints; power of 2, >=2
//  ID_W        $clog2(DEPTH)  checkpoint id width (derived, localparam)
// PORTS
//  clk              in   1                      clock, all state on rising edge
//  rst              in   1                      synchronous, active-high reset
//  regs_in          in   DATA_WIDTH x NUM_REGS  current reg-file image (unpacked [NUM_REGS])
//  push             in   1                      capture regs_in as new youngest checkpoint
//  push_ready       out  1                      !full; push accepted only when high
//  push_id          out  ID_W                   id the next accepted push receives (=tail)
//  commit           in   1                      oldest branch resolved correct: free oldest
//  restore          in   1                      mispredict: restore checkpoint restore_id
//  restore_id       in   ID_W                   checkpoint to roll back to
//  regs_snapshot    out  DATA_WIDTH x NUM_REGS  restored image, registered
//  restore_valid    out  1                      1-cycle pulse: regs_snapshot holds restored image
//  count            out  ID_W+1                 live checkpoints, 0..DEPTH
//  empty            out  1                      count==0
//  err              out  1                      sticky: illegal push/commit/restore seen
// BEHAVIOUR
//  Storage: circular buffer mem[DEPTH][NUM_REGS]; head=oldest, tail=next free; wrap mod DEPTH.
//  Reset (rst=1 at edge): head=tail=0, count=0, restore_valid=0, err=0, regs_snapshot all 0;
//   mem contents don't-care. push_ready=1, empty=1, push_id=0 after reset.
//  Push (push & push_ready & !restore): mem[tail]<=regs_in; tail++; count++. Image is regs_in
//   sampled at that edge. push while full: dropped, err<=1, no state change.
//  Commit (commit & !empty & !restore): head++; count--. commit while empty: ignored, err<=1.
//  Push+commit same cycle (no restore): both take effect; count unchanged; legal when full
//   only if push_ready (full push still dropped, commit still applies).
//  Restore: valid iff count!=0 and off=(restore_id-head) mod DEPTH < count.
//   Valid: regs_snapshot<=mem[restore_id]; restore_valid<=1 next cycle (latency 1);
//   tail<=restore_id; count<=off (restored entry and all younger freed); head unchanged.
//   Invalid: no state change, restore_valid stays 0, err<=1.
//  Restore has priority: push and commit in the same cycle are ignored (not errors).
//  restore_valid is high exactly one cycle per valid restore; back-to-back restores allowed.
//  regs_snapshot holds last restored image until the next valid restore or reset.
//  err clears only on reset. Reset mid-restore: rst wins, restore_valid=0 next cycle.
//  push_ready, push_id, count, empty combinational from registered state.
// TESTING (DEPTH=4, DATA_WIDTH=32)
//  Reset -> count=0, empty=1, push_ready=1, push_id=0, restore_valid=0, regs_snapshot=0.
//  Push images with r[i]=A0+i, B0+i, C0+i, D0+i -> ids 0..3, count=4, push_ready=0;
//   5th push -> dropped, err=1, count=4.
//  From 4 live: restore id 1 -> next cycle restore_valid=1, regs_snapshot[i]=B0+i,
//   count=1, push_id=1; following cycle restore_valid=0.
//  Commit x3 then push x3 (wrap): head=3, ids 3,0,1; restore id 0 -> image of 2nd push,
//   count=1; restore id 2 (not live) -> ignored, err=1.
//  Same cycle push+commit at count=2 -> count=2, head/tail both advance; push+restore same
//   cycle -> push ignored, restore applied.
//  Commit when empty -> err=1, count=0; assert rst during restore cycle -> all reset values.

Source files
------------

// File: rtl/register_checkpoint_buffer.sv
// Register-file checkpoint store for speculative branch execution.
// Holds up to DEPTH full register images in a circular buffer (head = oldest,
// tail = next free slot). A correct prediction retires the oldest image.
// A mispredict reads back one image and frees that image and every younger one.
module register_checkpoint_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     regs_in [NUM_REGS],
  input  logic                      push,
  output logic                      push_ready,
  output logic [$clog2(DEPTH)-1:0]  push_id,
  input  logic                      commit,
  input  logic                      restore,
  input  logic [$clog2(DEPTH)-1:0]  restore_id,
  output logic [DATA_WIDTH-1:0]     regs_snapshot [NUM_REGS],
  output logic                      restore_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      err
);

  localparam int ID_W = $clog2(DEPTH);
  localparam logic [ID_W:0] DEPTH_CNT = (ID_W+1)'(DEPTH);

  logic [ID_W-1:0] head_reg, head_next;
  logic [ID_W-1:0] tail_reg, tail_next;
  logic [ID_W:0]   count_reg, count_next;
  logic            err_reg, err_next;
  logic            restore_valid_reg;

  logic            full;
  logic            is_empty;
  logic [ID_W-1:0] restore_off;
  logic            restore_ok;
  logic            push_do;
  logic            commit_do;

  // Status flags and accepted-operation decode. A restore request of any
  // kind suppresses push and commit in that cycle, so they never count as errors.
  always_comb begin
    full        = (count_reg == DEPTH_CNT);
    is_empty    = (count_reg == '0);
    // DEPTH is a power of two, so modular distance is plain wraparound subtraction
    restore_off = restore_id - head_reg;
    restore_ok  = restore && !is_empty && ({1'b0, restore_off} < count_reg);
    push_do     = push && !full && !restore;
    commit_do   = commit && !is_empty && !restore;
  end

  // Next-state computation for the ring pointers, occupancy and sticky error.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    err_next   = err_reg;
    if (restore) begin
      if (restore_ok) begin
        // roll back: the restored slot becomes the next free slot
        tail_next  = restore_id;
        count_next = {1'b0, restore_off};
      end else begin
        err_next = 1'b1;
      end
    end else begin
      if (push_do) begin
        tail_next = tail_reg + 1'b1;
      end
      if (commit_do) begin
        head_next = head_reg + 1'b1;
      end
      case ({push_do, commit_do})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if ((push && full) || (commit && is_empty)) begin
        err_next = 1'b1;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      err_reg           <= 1'b0;
      restore_valid_reg <= 1'b0;
    end else begin
      head_reg          <= head_next;
      tail_reg          <= tail_next;
      count_reg         <= count_next;
      err_reg           <= err_next;
      restore_valid_reg <= restore_ok;
    end
  end

  // One independent memory bank per architectural register, each with a
  // single write port (tail) and a registered read port (restore_id), so
  // every bank maps onto a simple dual-port RAM.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] bank [DEPTH];

    // Capture this register's value into the slot at tail on an accepted push.
    always_ff @(posedge clk) begin
      if (push_do) begin
        bank[tail_reg] <= regs_in[gi];
      end
    end

    // Registered restore read; the snapshot holds until the next valid restore.
    always_ff @(posedge clk) begin
      if (rst) begin
        regs_snapshot[gi] <= '0;
      end else if (restore_ok) begin
        regs_snapshot[gi] <= bank[restore_id];
      end
    end
  end

  assign push_ready    = !full;
  assign push_id       = tail_reg;
  assign count         = count_reg;
  assign empty         = is_empty;
  assign err           = err_reg;
  assign restore_valid = restore_valid_reg;

endmodule

// File: tb/tb_register_checkpoint_buffer.sv
// Self-checking bench for register_checkpoint_buffer (DEPTH=4, 32x32 images).
// Restore results are predicted into a scoreboard queue by the driver and
// checked by a separate monitor whenever restore_valid is seen.
module tb_register_checkpoint_buffer;

  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int DEPTH = 4;
  localparam int ID_W  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   regs_in [NR];
  logic            push;
  logic            push_ready;
  logic [ID_W-1:0] push_id;
  logic            commit;
  logic            restore;
  logic [ID_W-1:0] restore_id;
  logic [DW-1:0]   regs_snapshot [NR];
  logic            restore_valid;
  logic [ID_W:0]   count;
  logic            empty;
  logic            err;

  typedef struct {
    logic [DW-1:0] base;
    int            cnt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  register_checkpoint_buffer #(.DATA_WIDTH(DW), .NUM_REGS(NR), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .regs_in       (regs_in),
    .push          (push),
    .push_ready    (push_ready),
    .push_id       (push_id),
    .commit        (commit),
    .restore       (restore),
    .restore_id    (restore_id),
    .regs_snapshot (regs_snapshot),
    .restore_valid (restore_valid),
    .count         (count),
    .empty         (empty),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) begin
      n_pass++;
      $display("check %s: got 0x%0h ok", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Image whose register i holds base+i.
  task automatic set_image(input logic [DW-1:0] base);
    for (int i = 0; i < NR; i++) regs_in[i] = base + DW'(i);
  endtask

  // Apply the currently driven inputs for one rising edge, then release them.
  task automatic tick();
    @(posedge clk);
    #1;
    push    = 1'b0;
    commit  = 1'b0;
    restore = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic do_push(input logic [DW-1:0] base);
    set_image(base);
    push = 1'b1;
    tick();
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
  endtask

  task automatic do_restore(input logic [ID_W-1:0] id);
    restore    = 1'b1;
    restore_id = id;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  // Monitor: every restore_valid pulse must match the oldest predicted restore.
  initial begin
    exp_t e;
    int   bad_idx;
    forever begin
      @(negedge clk);
      if (restore_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_restore_valid: got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          bad_idx = -1;
          for (int i = 0; i < NR; i++)
            if (regs_snapshot[i] !== e.base + DW'(i) && bad_idx < 0) bad_idx = i;
          if (bad_idx < 0) chk({e.name, "_image"}, 64'(regs_snapshot[0]), 64'(e.base));
          else chk({e.name, "_image_reg"}, 64'(regs_snapshot[bad_idx]), 64'(e.base + DW'(bad_idx)));
          chk({e.name, "_count"}, 64'(count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    logic zero_ok;
    rst = 1'b1; push = 1'b0; commit = 1'b0; restore = 1'b0; restore_id = '0;
    set_image('0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_push_ready", 64'(push_ready), 1);
    chk("rst_push_id", 64'(push_id), 0);
    chk("rst_restore_valid", 64'(restore_valid), 0);
    chk("rst_err", 64'(err), 0);
    zero_ok = 1'b1;
    for (int i = 0; i < NR; i++) if (regs_snapshot[i] !== '0) zero_ok = 1'b0;
    chk("rst_snapshot_zero", 64'(zero_ok), 1);

    // Fill all four slots, then overflow
    chk("fill_id0", 64'(push_id), 0);
    do_push(32'hA000_0000);
    chk("fill_id1", 64'(push_id), 1);
    do_push(32'hB000_0000);
    chk("fill_id2", 64'(push_id), 2);
    do_push(32'hC000_0000);
    chk("fill_id3", 64'(push_id), 3);
    do_push(32'hD000_0000);
    chk("full_count", 64'(count), 4);
    chk("full_push_ready", 64'(push_ready), 0);
    chk("full_err_clear", 64'(err), 0);
    do_push(32'hE000_0000);
    chk("overflow_err", 64'(err), 1);
    chk("overflow_count", 64'(count), 4);

    // Restore id 1 from four live checkpoints
    exp_q.push_back('{32'hB000_0000, 1, "restore_id1"});
    do_restore(2'd1);
    chk("r1_valid", 64'(restore_valid), 1);
    chk("r1_push_id", 64'(push_id), 1);
    tick();
    chk("r1_valid_drop", 64'(restore_valid), 0);

    // Wraparound: three commits move head to 3, then three pushes take ids 3,0,1
    do_reset();
    do_push(32'h1000_0000);
    do_push(32'h2000_0000);
    do_push(32'h3000_0000);
    do_commit(); do_commit(); do_commit();
    chk("wrap_empty", 64'(empty), 1);
    chk("wrap_id3", 64'(push_id), 3);
    do_push(32'h4000_0000);
    chk("wrap_id0", 64'(push_id), 0);
    do_push(32'h5000_0000);
    chk("wrap_id1", 64'(push_id), 1);
    do_push(32'h6000_0000);
    chk("wrap_count", 64'(count), 3);
    exp_q.push_back('{32'h5000_0000, 1, "restore_wrap_id0"});
    do_restore(2'd0);
    tick();
    chk("wrap_err_clear", 64'(err), 0);
    do_restore(2'd2);
    chk("dead_restore_err", 64'(err), 1);
    chk("dead_restore_count", 64'(count), 1);
    chk("dead_restore_valid", 64'(restore_valid), 0);

    // Push and commit together at count 2
    do_reset();
    do_push(32'h7000_0000);
    do_push(32'h8000_0000);
    set_image(32'h9000_0000);
    push = 1'b1; commit = 1'b1;
    tick();
    chk("pc_count", 64'(count), 2);
    chk("pc_push_id", 64'(push_id), 3);
    // head is now 1: slot 2 sits one past head, so its restore leaves count 1
    exp_q.push_back('{32'h9000_0000, 1, "restore_after_pc"});
    do_restore(2'd2);
    tick();
    // push together with restore: push ignored, restore applied
    set_image(32'hF000_0000);
    push = 1'b1;
    exp_q.push_back('{32'h8000_0000, 0, "restore_with_push"});
    do_restore(2'd1);
    chk("pr_push_id", 64'(push_id), 1);
    chk("pr_err_clear", 64'(err), 0);
    tick();
    chk("pr_count", 64'(count), 0);

    // Commit on empty
    do_commit();
    chk("empty_commit_err", 64'(err), 1);
    chk("empty_commit_count", 64'(count), 0);

    // Reset coinciding with a valid restore
    do_push(32'h1100_0000);
    rst = 1'b1;
    do_restore(2'd1);
    chk("rr_valid", 64'(restore_valid), 0);
    chk("rr_count", 64'(count), 0);
    chk("rr_err", 64'(err), 0);
    chk("rr_push_id", 64'(push_id), 0);
    zero_ok = 1'b1;
    for (int i = 0; i < NR; i++) if (regs_snapshot[i] !== '0) zero_ok = 1'b0;
    chk("rr_snapshot_zero", 64'(zero_ok), 1);
    tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
